// File: rtl/bitscan.sv
// Lowest-set-bit isolator: sel keeps only the least significant 1 of req.
module bitscan #(
    parameter int W = 16
) (
    input  logic [W-1:0] req,
    output logic [W-1:0] sel
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    assign sel = req & ~(req - ONE);

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with a held one-hot grant, released when the owner drops
// its request or an optional hold timeout expires. One dead cycle between grants.
module rr_grant_arbiter #(
    parameter int WIDTH    = 16,
    parameter int IDX_W    = 4,
    parameter int MAX_HOLD = 0,
    parameter int HOLD_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    localparam logic IDLE = 1'b0;
    localparam logic BUSY = 1'b1;

    localparam logic [WIDTH-1:0]  ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    logic              state;
    logic [WIDTH-1:0]  mask;
    logic [HOLD_W-1:0] hold_cnt;

    logic [WIDTH-1:0]  masked;
    logic [WIDTH-1:0]  sel_masked;
    logic [WIDTH-1:0]  sel_plain;
    logic [WIDTH-1:0]  pick;
    logic [IDX_W-1:0]  pick_idx;
    logic [WIDTH-1:0]  above_owner;
    logic              release_now;

    assign masked = req & mask;

    bitscan #(.W(WIDTH)) u_scan_masked (
        .req (masked),
        .sel (sel_masked)
    );

    bitscan #(.W(WIDTH)) u_scan_plain (
        .req (req),
        .sel (sel_plain)
    );

    // An empty masked vector means everyone above the last owner is idle,
    // so priority wraps back to bit 0.
    assign pick = (masked != '0) ? sel_masked : sel_plain;

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pick[i]) begin
                pick_idx = pick_idx | IDX_W'(i);
            end
        end
    end

    // Owner at the top bit shifts out to zero, giving an empty mask.
    assign above_owner = ~((grant << 1) - ONE);

    assign release_now = ((req & grant) == '0) ||
                         ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            mask        <= '1;
            hold_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != '0) begin
                        grant       <= pick;
                        grant_valid <= 1'b1;
                        grant_idx   <= pick_idx;
                        hold_cnt    <= '0;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        grant_idx   <= '0;
                        mask        <= above_owner;
                        state       <= IDLE;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
